// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-side controller for a 4-phase bundled-data
// clock-domain crossing. It accepts a word on a valid/ready port, holds it
// on xfer_data, and runs req/ack through an M-flop synchronizer on the
// returning acknowledge.
//
// Handshake contract (local port): a word moves when in_valid and in_ready
// are both 1 at a rising clk edge. in_ready is a pure decode of the state
// register and never depends combinationally on in_valid. in_valid may be
// raised or dropped at any time. While in_ready is 0, in_valid is ignored and
// no word is captured.
module cdc_handshake_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int M          = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  xfer_req,
    output logic [DATA_WIDTH-1:0] xfer_data,
    input  logic                  xfer_ack_async,
    output logic                  done,
    output logic                  busy,
    output logic                  err_timeout,
    output logic [15:0]           xfer_count,
    output logic [1:0]            dbg_state
);

    // A single flop cannot resolve metastability on the asynchronous ack.
    if (M < 2) begin : g_bad_m
        $error("cdc_handshake_tx: M must be at least 2");
    end

    // A zero TIMEOUT disables the check. A one-bit counter is still kept so
    // that no signal ends up with zero width.
    localparam int          CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);
    localparam bit          TMO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    logic [M-1:0]          r_ack_s;
    logic                  r_xfer_req;
    logic [DATA_WIDTH-1:0] r_xfer_data;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_err;
    logic [15:0]           r_xfer_count;
    logic [CW-1:0]         r_phase_cnt;

    logic                  w_ack_sync;
    logic                  w_phase_exit;

    assign w_ack_sync  = r_ack_s[M-1];
    assign in_ready    = (r_state == ST_IDLE);
    assign xfer_req    = r_xfer_req;
    assign xfer_data   = r_xfer_data;
    assign done        = r_done;
    assign busy        = r_busy;
    assign err_timeout = r_err;
    assign xfer_count  = r_xfer_count;
    assign dbg_state   = r_state;

    // Shift the asynchronous ack through the M-flop synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_s <= '0;
        end else begin
            r_ack_s <= {r_ack_s[M-2:0], xfer_ack_async};
        end
    end

    // Flag the cycles in which the FSM leaves its current state.
    always_comb begin
        w_phase_exit = 1'b0;
        case (r_state)
            ST_IDLE:    w_phase_exit = in_valid;
            ST_REQ:     w_phase_exit = w_ack_sync;
            ST_RELEASE: w_phase_exit = !w_ack_sync;
            default:    w_phase_exit = 1'b1;
        endcase
    end

    // Handshake FSM with registered req, data, busy, done and transfer count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_xfer_req   <= 1'b0;
            r_xfer_data  <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_xfer_count <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A stale high ack is tolerated here: REQ then exits at
                    // once, and RELEASE still waits for the ack to drop.
                    if (in_valid) begin
                        r_xfer_data <= in_data;
                        r_xfer_req  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_sync) begin
                        r_xfer_req <= 1'b0;
                        r_state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_sync) begin
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_xfer_count <= r_xfer_count + 16'd1;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_xfer_req <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating phase counter: cleared on every state change, counts in REQ/RELEASE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase_cnt <= '0;
        end else if (w_phase_exit || (r_state == ST_IDLE)) begin
            r_phase_cnt <= '0;
        end else if (r_phase_cnt != TMO) begin
            r_phase_cnt <= r_phase_cnt + CW'(1);
        end
    end

    // Sticky timeout flag. The FSM keeps waiting after it sets.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (TMO_EN && (r_phase_cnt == TMO)) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: table-driven single transfer,
// scoreboarded data path, timeout, reset mid-handshake, counter wrap and
// jittered asynchronous ack on a second instance with M=3.
module tb_cdc_handshake_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;

    // instance A: M=2, TIMEOUT=16
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        xfer_req;
    logic [7:0]  xfer_data;
    logic        ack = 1'b0;
    logic        done;
    logic        busy;
    logic        err;
    logic [15:0] count;
    logic [1:0]  dbg_state;

    // instance B: M=3, TIMEOUT=0 (check disabled)
    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [7:0]  in_data3 = 8'h00;
    logic        xfer_req3;
    logic [7:0]  xfer_data3;
    logic        ack3 = 1'b0;
    logic        done3;
    logic        busy3;
    logic        err3;
    logic [15:0] count3;
    logic [1:0]  dbg_state3;

    cdc_handshake_tx #(.DATA_WIDTH(8), .M(2), .TIMEOUT(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack_async(ack),
        .done(done), .busy(busy), .err_timeout(err), .xfer_count(count),
        .dbg_state(dbg_state)
    );

    cdc_handshake_tx #(.DATA_WIDTH(8), .M(3), .TIMEOUT(0)) u_dut3 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .xfer_req(xfer_req3), .xfer_data(xfer_data3), .xfer_ack_async(ack3),
        .done(done3), .busy(busy3), .err_timeout(err3), .xfer_count(count3),
        .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q3[$];
    logic       prev_req = 1'b0, prev_req3 = 1'b0;
    logic [7:0] prev_data = 8'h00, prev_data3 = 8'h00;
    logic       ack_auto = 1'b0;
    logic [2:0] ack_hist = 3'b000;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: remember what the edge will accept, step to 1 time unit past
    // the edge, then score done pulses, data stability and run the ack echo.
    task automatic tick();
        logic       acc, acc3, rst;
        logic [7:0] d, d3, e;
        acc  = in_valid && in_ready && !reset;
        acc3 = in_valid3 && in_ready3 && !reset;
        d    = in_data;
        d3   = in_data3;
        rst  = reset;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_q3.delete();
        end
        if (acc)  exp_q.push_back(d);
        if (acc3) exp_q3.push_back(d3);
        if (done) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(xfer_data), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_data", 64'(xfer_data), 64'(e));
            end
        end
        if (done3) begin
            if (exp_q3.size() == 0) begin
                check_eq("sb3_underflow", 64'(xfer_data3), 64'hFFFF);
            end else begin
                e = exp_q3.pop_front();
                check_eq("sb3_data", 64'(xfer_data3), 64'(e));
            end
        end
        if (xfer_req && prev_req && !rst)   check_eq("stable", 64'(xfer_data), 64'(prev_data));
        if (xfer_req3 && prev_req3 && !rst) check_eq("stable3", 64'(xfer_data3), 64'(prev_data3));
        prev_req   = xfer_req;
        prev_data  = xfer_data;
        prev_req3  = xfer_req3;
        prev_data3 = xfer_data3;
        if (ack_auto) begin
            ack_hist = {ack_hist[1:0], xfer_req};
            ack      = ack_hist[2];
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        ack_auto  = 1'b0;
        ack       = 1'b0;
        ack3      = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    // Tick until done pulses on instance A, at most lim cycles.
    task automatic wait_done(input int lim, output logic got);
        got = 1'b0;
        for (int c = 0; c < lim && !got; c++) begin
            tick();
            if (done) got = 1'b1;
        end
    endtask

    // ---------------- single-transfer vector table ----------------
    // inputs {valid, data, ack}; expected {ready, req, busy, done, data, count}
    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        a;
        logic [27:0] exp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic       got;
        int         n;
        int         nd;
        int         idx;
        logic       rdy;

        tbl[0] = {1'b1, 8'hA5, 1'b0, 4'b0110, 8'hA5, 16'd0};
        tbl[1] = {1'b1, 8'h5A, 1'b0, 4'b0110, 8'hA5, 16'd0}; // ignored while busy
        tbl[2] = {1'b0, 8'h00, 1'b1, 4'b0110, 8'hA5, 16'd0}; // ack rises before t1
        tbl[3] = {1'b0, 8'h00, 1'b1, 4'b0110, 8'hA5, 16'd0};
        tbl[4] = {1'b0, 8'h00, 1'b1, 4'b0010, 8'hA5, 16'd0}; // req falls at t1+2
        tbl[5] = {1'b0, 8'h00, 1'b0, 4'b0010, 8'hA5, 16'd0}; // ack falls before t2
        tbl[6] = {1'b0, 8'h00, 1'b0, 4'b0010, 8'hA5, 16'd0};
        tbl[7] = {1'b0, 8'h00, 1'b0, 4'b1001, 8'hA5, 16'd1}; // done at t2+2
        tbl[8] = {1'b0, 8'h00, 1'b0, 4'b1000, 8'hA5, 16'd1};

        // reset state of both instances
        do_reset();
        check_eq("reset_a", 64'({in_ready, xfer_req, busy, done, err, xfer_data, count, dbg_state}),
                 64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 2'b00}));
        check_eq("reset_b", 64'({in_ready3, xfer_req3, busy3, done3, err3, xfer_data3, count3, dbg_state3}),
                 64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0, 2'b00}));

        // single transfer, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            ack      = tbl[i].a;
            tick();
            check_eq($sformatf("vec%0d", i),
                     64'({in_ready, xfer_req, busy, done, xfer_data, count}), 64'(tbl[i].exp));
        end

        // back-to-back words 01..04 with in_valid held, echoing destination
        do_reset();
        ack_auto = 1'b1;
        ack_hist = 3'b000;
        idx      = 0;
        nd       = 0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        for (int c = 0; c < 200 && (idx < 4 || nd < 4); c++) begin
            rdy = in_ready && in_valid;
            tick();
            if (done) nd++;
            if (rdy) begin
                idx++;
                in_data = 8'(idx + 1);
                if (idx == 4) in_valid = 1'b0;
            end
        end
        check_eq("b2b_done_pulses", 64'(nd), 64'd4);
        check_eq("b2b_count", 64'(count), 64'd4);
        check_eq("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // timeout: ack withheld
        do_reset();
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();                       // edge t0
        in_valid = 1'b0;
        repeat (16) tick();           // after t0+16
        check_eq("tmo_not_yet", 64'(err), 64'd0);
        tick();                       // after t0+17
        check_eq("tmo_set", 64'({err, xfer_req}), 64'b11);
        repeat (10) tick();
        check_eq("tmo_sticky", 64'({err, xfer_req}), 64'b11);
        ack = 1'b1;
        n   = 0;
        for (int c = 0; c < 10 && xfer_req; c++) begin
            tick();
            n++;
        end
        check_eq("tmo_req_drop", 64'(xfer_req), 64'd0);
        ack = 1'b0;
        wait_done(10, got);
        check_eq("tmo_late_done", 64'({got, err, count}), 64'({1'b1, 1'b1, 16'd1}));

        // reset while in RELEASE
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_valid = 1'b0;
        ack      = 1'b1;
        for (int c = 0; c < 10 && xfer_req; c++) tick();
        check_eq("in_release", 64'({busy, xfer_req, in_ready}), 64'b100);
        reset = 1'b1;
        ack   = 1'b0;
        tick();
        check_eq("mid_reset", 64'({xfer_req, count, in_ready, busy, done, err, xfer_data}),
                 64'({1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}));
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        check_eq("accept_after_reset", 64'({xfer_req, in_ready, xfer_data}), 64'({1'b1, 1'b0, 8'h3C}));
        in_valid = 1'b0;
        ack_auto = 1'b1;
        ack_hist = 3'b000;
        wait_done(30, got);
        check_eq("post_reset_done", 64'({got, count}), 64'({1'b1, 16'd1}));

        // counter wrap via a forced preload
        repeat (8) tick();
        force u_dut.r_xfer_count = 16'hFFFF;
        tick();
        release u_dut.r_xfer_count;
        tick();
        check_eq("preload_hold", 64'(count), 64'hFFFF);
        in_valid = 1'b1;
        in_data  = 8'hE1;
        tick();
        in_valid = 1'b0;
        wait_done(30, got);
        check_eq("wrap", 64'({got, count}), 64'({1'b1, 16'd0}));
        repeat (8) tick();
        ack_auto = 1'b0;

        // jittered async ack on instance B (M=3)
        for (int w = 0; w < 6; w++) begin
            in_valid3 = 1'b1;
            in_data3  = 8'($urandom_range(0, 255));
            tick();
            in_valid3 = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            #($urandom_range(0, 7));
            ack3 = 1'b1;
            n = 0;
            for (int c = 0; c < 12 && xfer_req3; c++) begin
                tick();
                n++;
            end
            check_eq($sformatf("jit_req_fall%0d", w), 64'(n), 64'd4);
            repeat ($urandom_range(0, 3)) tick();
            #($urandom_range(0, 7));
            ack3 = 1'b0;
            n = 0;
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                tick();
                n++;
                if (done3) got = 1'b1;
            end
            check_eq($sformatf("jit_done%0d", w), 64'({got, 8'(n), count3, err3}),
                     64'({1'b1, 8'd4, 16'(w + 1), 1'b0}));
            tick();
        end
        check_eq("queues_drained", 64'(exp_q.size() + exp_q3.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
